piece_step_ctrl: RTL
====================

Name: piece_step_ctrl

Overview:
- Sequencing FSM for the falling-piece register bank: the border/rho register block plus its next-position datapath.
- Decides when to reload a new figure (is_load_fig) and when to commit a computed move (write_reg).
- Issues gravity drops from an internal timer and arbitrates them against player left/right/rotate pulses.
- Handles collision, lock, line-clear handshake and game over; sits between the input debouncers and the board datapath.

Parameters:
- WIDTH, 8, width of the figure code; matches the register bank word width.
- NUM_FIG, 7, number of figure codes; the selector cycles 0..NUM_FIG-1. Code 0 = I, code 1 = Q.
- DROP_PERIOD, 25000000, IDLE cycles between gravity drops; must be >= 2.
- CNT_W, 25, drop counter width; must satisfy 2^CNT_W >= DROP_PERIOD.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- btn_left  in  1  one-cycle move-left request pulse.
- btn_right  in  1  one-cycle move-right request pulse.
- btn_rot  in  1  one-cycle rotate request pulse.
- collide  in  1  combinational result from the datapath: the position selected by move_op overlaps the field or a wall.
- clear_done  in  1  pulse from the field/line-clear logic: merge and clear are finished.
- move_op  out  3  selects the next-position computation: 0 NONE, 1 DOWN, 2 LEFT, 3 RIGHT, 4 ROT.
- write_reg  out  1  load enable for the border/rho registers.
- is_load_fig  out  1  reloads rho to the spawn shape of `figure`.
- figure  out  WIDTH  code of the current piece; registered.
- lock_req  out  1  one-cycle request to merge the piece into the field and clear full lines.
- game_over  out  1  sticky game-over flag.
- piece_cnt  out  16  number of pieces locked; wraps at 65535->0.

Behaviour:
- States: SPAWN, SPAWN_CHK, IDLE, EVAL, LOCK, WAIT_CLR, OVER. All transitions occur on the clk edge.
- Reset (rst=1 at an edge, from any state, including mid-EVAL or WAIT_CLR):
  - state=SPAWN; figure=0; fig_sel=0; drop_cnt=0; op_q=NONE; piece_cnt=0; game_over=0.
  - write_reg, is_load_fig and lock_req are combinational from the state and are therefore 0 while rst is high.
- fig_sel: free-running 0..NUM_FIG-1, increments every cycle and wraps to 0. figure <= fig_sel on every transition into SPAWN except the reset path.
- SPAWN: is_load_fig=1 for exactly one cycle; drop_cnt<=0; move_op=NONE. Next state SPAWN_CHK.
- SPAWN_CHK: move_op=NONE.
  - collide=1 -> OVER.
  - collide=0 -> IDLE.
- IDLE: move_op=NONE; drop_cnt increments each cycle.
  - Request priority within one cycle: drop (drop_cnt==DROP_PERIOD-1) > rot > left > right. The winner is latched into op_q; go to EVAL.
  - A drop also sets drop_cnt<=0.
  - Losing pulses in the same cycle are discarded. Button pulses in any state other than IDLE are discarded.
- EVAL: move_op=op_q; drop_cnt holds its value.
  - collide=0 -> write_reg=1 this cycle; next state IDLE.
  - collide=1 and op_q=DOWN -> write_reg=0; next state LOCK.
  - collide=1 otherwise -> write_reg=0; next state IDLE (move rejected, piece unchanged).
- Latency: a request accepted in IDLE at cycle t produces write_reg at t+1, and the register bank updates at the t+1 edge.
- LOCK: lock_req=1 for one cycle; piece_cnt<=piece_cnt+1. Next state WAIT_CLR.
- WAIT_CLR: waits indefinitely for clear_done.
  - clear_done=1 -> SPAWN, with figure<=fig_sel.
  - A clear_done pulse arriving in any other state is ignored.
- OVER: game_over=1. All enables are 0 and move_op=NONE. The only exit is rst.
- write_reg and is_load_fig are never asserted in the same cycle. lock_req is never asserted together with either of them.

Decomposition:
- Shared package piece_pkg holds:
  - move_op encodings: OP_NONE, OP_DOWN, OP_LEFT, OP_RIGHT, OP_ROT.
  - FSM state encodings.
  - Figure codes: FIG_I=0, FIG_Q=1.
- One sub-module, drop_timer, wraps the CNT_W counter.
  - Inputs: clk, rst, en (IDLE), clr (SPAWN or drop).
  - Output: drop pulse when count==DROP_PERIOD-1.
- The FSM, request arbitration, fig_sel and piece_cnt stay in the top module.

Test Plan:
- Bench parameters: DROP_PERIOD=4, NUM_FIG=7.
- Reset: hold rst 2 cycles, then release.
  - -> is_load_fig=1 in the first cycle after release, with figure=0.
  - With collide=0 -> IDLE. After 4 IDLE cycles, EVAL with move_op=1 and write_reg=1.
- Simultaneous requests: btn_rot and btn_left in the same IDLE cycle with drop_cnt=1.
  - -> next cycle move_op=4 with a single write_reg pulse; left is never executed.
- Drop priority: btn_right in the IDLE cycle where drop_cnt=3.
  - -> move_op=1 (DOWN); right is dropped; drop_cnt=0 afterwards.
- Lock sequence: collide=1 during a DOWN EVAL.
  - -> write_reg=0, lock_req pulse next cycle, piece_cnt 0->1.
  - Hold clear_done low for 10 cycles -> stays in WAIT_CLR.
  - Pulse clear_done -> is_load_fig next cycle, with figure equal to the fig_sel value sampled at that edge.
- Game over: collide=1 in SPAWN_CHK.
  - -> game_over=1 and sticky; button pulses and clear_done give no write_reg, lock_req or is_load_fig.
  - rst clears game_over and restarts the SPAWN sequence.
- Reset mid-op: rst in WAIT_CLR -> state SPAWN, piece_cnt=0, figure=0, no lock_req.

Source files
------------

// File: rtl/piece_pkg.sv
// Shared encodings for the falling-piece sequencer: move operations,
// FSM states and the fixed figure codes.
package piece_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_DOWN  = 3'd1,
    OP_LEFT  = 3'd2,
    OP_RIGHT = 3'd3,
    OP_ROT   = 3'd4
  } move_op_e;

  typedef enum logic [2:0] {
    ST_SPAWN     = 3'd0,
    ST_SPAWN_CHK = 3'd1,
    ST_IDLE      = 3'd2,
    ST_EVAL      = 3'd3,
    ST_LOCK      = 3'd4,
    ST_WAIT_CLR  = 3'd5,
    ST_OVER      = 3'd6
  } state_e;

  localparam logic [7:0] FIG_I = 8'd0;
  localparam logic [7:0] FIG_Q = 8'd1;

endpackage

// File: rtl/piece_step_ctrl_drop_timer.sv
// Gravity timer: counts enabled cycles and flags the cycle in which the
// count reaches DROP_PERIOD-1.
module drop_timer #(
  parameter int unsigned DROP_PERIOD = 25000000,
  parameter int unsigned CNT_W       = 25
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic drop_o
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DROP_PERIOD - 32'd1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // clear wins over count so a drop restarts the period at zero
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // counter register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign drop_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/piece_step_ctrl.sv
// Sequencer for the falling-piece register bank: spawns figures, arbitrates
// gravity against player moves, and runs the lock / line-clear handshake.
module piece_step_ctrl
  import piece_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned NUM_FIG     = 7,
  parameter int unsigned DROP_PERIOD = 25000000,
  parameter int unsigned CNT_W       = 25
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_rot,
  input  logic             collide,
  input  logic             clear_done,
  output logic [2:0]       move_op,
  output logic             write_reg,
  output logic             is_load_fig,
  output logic [WIDTH-1:0] figure,
  output logic             lock_req,
  output logic             game_over,
  output logic [15:0]      piece_cnt
);

  localparam logic [WIDTH-1:0] LAST_FIG = WIDTH'(NUM_FIG - 32'd1);

  state_e           state_q, state_d;
  move_op_e         op_q, op_d;
  logic [WIDTH-1:0] fig_sel_q, fig_sel_d;
  logic [WIDTH-1:0] figure_q, figure_d;
  logic [15:0]      piece_cnt_q, piece_cnt_d;
  logic             game_over_q, game_over_d;
  logic             drop_s;

  drop_timer #(
    .DROP_PERIOD(DROP_PERIOD),
    .CNT_W      (CNT_W)
  ) u_drop_timer (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (state_q == ST_IDLE),
    .clr_i ((state_q == ST_SPAWN) || drop_s),
    .drop_o(drop_s)
  );

  // next-state logic; in IDLE gravity outranks rotate, then left, then right
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    figure_d    = figure_q;
    piece_cnt_d = piece_cnt_q;
    game_over_d = game_over_q;
    fig_sel_d   = (fig_sel_q == LAST_FIG) ? '0 : fig_sel_q + WIDTH'(1);
    case (state_q)
      ST_SPAWN: state_d = ST_SPAWN_CHK;
      ST_SPAWN_CHK: begin
        if (collide) begin
          state_d     = ST_OVER;
          game_over_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (drop_s) begin
          op_d    = OP_DOWN;
          state_d = ST_EVAL;
        end else if (btn_rot) begin
          op_d    = OP_ROT;
          state_d = ST_EVAL;
        end else if (btn_left) begin
          op_d    = OP_LEFT;
          state_d = ST_EVAL;
        end else if (btn_right) begin
          op_d    = OP_RIGHT;
          state_d = ST_EVAL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EVAL: begin
        if (collide && (op_q == OP_DOWN)) begin
          state_d = ST_LOCK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCK: begin
        piece_cnt_d = piece_cnt_q + 16'd1;
        state_d     = ST_WAIT_CLR;
      end
      ST_WAIT_CLR: begin
        if (clear_done) begin
          figure_d = fig_sel_q;
          state_d  = ST_SPAWN;
        end else begin
          state_d = ST_WAIT_CLR;
        end
      end
      ST_OVER: begin
        state_d     = ST_OVER;
        game_over_d = 1'b1;
      end
      default: state_d = ST_SPAWN;
    endcase
  end

  // FSM and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SPAWN;
      op_q        <= OP_NONE;
      fig_sel_q   <= '0;
      figure_q    <= WIDTH'(FIG_I);
      piece_cnt_q <= 16'd0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      fig_sel_q   <= fig_sel_d;
      figure_q    <= figure_d;
      piece_cnt_q <= piece_cnt_d;
      game_over_q <= game_over_d;
    end
  end

  // enables decode from state only, forced low while reset is asserted
  always_comb begin
    move_op     = OP_NONE;
    write_reg   = 1'b0;
    is_load_fig = 1'b0;
    lock_req    = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_SPAWN: is_load_fig = 1'b1;
        ST_EVAL: begin
          move_op   = op_q;
          write_reg = !collide;
        end
        ST_LOCK: lock_req = 1'b1;
        default: move_op = OP_NONE;
      endcase
    end else begin
      move_op = OP_NONE;
    end
  end

  assign figure    = figure_q;
  assign game_over = game_over_q;
  assign piece_cnt = piece_cnt_q;

endmodule
